// File: rtl/popcount_acc_pipe.sv
// Pipelined popcount accumulator: grouped bit counts, registered adder tree, per-packet sum.
// Optional feature macro POPCNT_SAT_EN: saturating accumulation with sticky out_sat.
module popcount_acc_pipe #(
   parameter int unsigned IN_W  = 12,
   parameter int unsigned GRP_W = 6,
   parameter int unsigned ACC_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic             out_sat
);
   localparam int unsigned CNT_W  = $clog2(IN_W + 1);
   localparam int unsigned N_GRP  = (IN_W + GRP_W - 1) / GRP_W;
   localparam int unsigned PAD_W  = N_GRP * GRP_W;
   localparam int unsigned GCNT_W = $clog2(GRP_W + 1);

   logic                         w_en;
   logic [PAD_W-1:0]             w_pad;
   logic [N_GRP-1:0][GCNT_W-1:0] w_grp_cnt;
   logic [CNT_W-1:0]             w_beat_cnt;
   logic [ACC_W-1:0]             w_tot;

   logic [N_GRP-1:0][GCNT_W-1:0] r_s1_cnt;
   logic                         r_s1_vld;
   logic                         r_s1_last;
   logic [CNT_W-1:0]             r_s2_cnt;
   logic                         r_s2_vld;
   logic                         r_s2_last;
   logic [ACC_W-1:0]             r_acc;
   logic                         r_out_valid;
   logic [ACC_W-1:0]             r_out_sum;

   // A held, unaccepted result freezes the whole pipe so nothing is overwritten.
   assign w_en      = !(r_out_valid && !out_ready);
   assign in_ready  = rst_n && w_en;
   assign out_valid = r_out_valid;
   assign out_sum   = r_out_sum;

   // Last group is zero-padded when IN_W is not a multiple of GRP_W.
   assign w_pad = PAD_W'(in_data);

   for (genvar g = 0; g < N_GRP; g++) begin : g_grp
      logic [GRP_W-1:0]  w_bits;
      logic [GCNT_W-1:0] w_cnt;
      assign w_bits = w_pad[g*GRP_W +: GRP_W];
      always_comb begin
         w_cnt = '0;
         for (int b = 0; b < GRP_W; b++) begin
            w_cnt = w_cnt + GCNT_W'(w_bits[b]);
         end
      end
      assign w_grp_cnt[g] = w_cnt;
   end

   // Second tree level; the sum never exceeds IN_W so CNT_W is exact.
   always_comb begin
      w_beat_cnt = '0;
      for (int g = 0; g < N_GRP; g++) begin
         w_beat_cnt = w_beat_cnt + CNT_W'(r_s1_cnt[g]);
      end
   end

`ifdef POPCNT_SAT_EN
   localparam int unsigned SUM_W = ACC_W + 1;

   logic [SUM_W-1:0] w_tot_raw;
   logic             w_sat_pkt;
   logic             r_sat_flag;
   logic             r_out_sat;

   assign w_tot_raw = {1'b0, r_acc} + SUM_W'(r_s2_cnt);
   assign w_tot     = w_tot_raw[ACC_W] ? '1 : w_tot_raw[ACC_W-1:0];
   assign w_sat_pkt = r_sat_flag | w_tot_raw[ACC_W];
   assign out_sat   = r_out_sat;

   // Sticky clamp flag follows the accumulator and is reported with the packet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sat_flag <= 1'b0;
         r_out_sat  <= 1'b0;
      end else if (w_en && r_s2_vld) begin
         if (r_s2_last) begin
            r_out_sat  <= w_sat_pkt;
            r_sat_flag <= 1'b0;
         end else begin
            r_sat_flag <= w_sat_pkt;
         end
      end
   end
`else
   assign w_tot   = r_acc + ACC_W'(r_s2_cnt);
   assign out_sat = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_cnt    <= '0;
         r_s1_vld    <= 1'b0;
         r_s1_last   <= 1'b0;
         r_s2_cnt    <= '0;
         r_s2_vld    <= 1'b0;
         r_s2_last   <= 1'b0;
         r_acc       <= '0;
         r_out_valid <= 1'b0;
         r_out_sum   <= '0;
      end else if (w_en) begin
         r_s1_cnt    <= w_grp_cnt;
         r_s1_vld    <= in_valid;
         r_s1_last   <= in_last;
         r_s2_cnt    <= w_beat_cnt;
         r_s2_vld    <= r_s1_vld;
         r_s2_last   <= r_s1_last;
         // With en high any current result is being consumed, so valid follows the load.
         r_out_valid <= r_s2_vld && r_s2_last;
         if (r_s2_vld) begin
            if (r_s2_last) begin
               r_out_sum <= w_tot;
               r_acc     <= '0;
            end else begin
               r_acc     <= w_tot;
            end
         end
      end
   end

endmodule
